// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_write_arbiter
//  Purpose  : Round-robin owner of the frame-buffer write port; each grant
//             covers a whole burst and is force-released after MAX_BURST.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 3,
    parameter int MAX_BURST = 1024
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [2:0]            req,
    input  logic [3*ADDR_W-1:0]   waddr,
    input  logic [3*DATA_W-1:0]   wdata,
    input  logic [2:0]            wen,
    output logic [2:0]            grant,
    output logic [1:0]            owner,
    output logic                  preempt,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wenable
);

    localparam int CNT_W = $clog2(MAX_BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [1:0]       c_NO_OWNER = 2'd3;
    localparam logic [1:0]       c_LAST_RST = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]        r_state;
    logic [2:0]        r_grant;
    logic [1:0]        r_owner;
    logic [1:0]        r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_preempt;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wen;

    logic [1:0]        w_state_nxt;
    logic [2:0]        w_grant_nxt;
    logic [1:0]        w_owner_nxt;
    logic [1:0]        w_last_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_preempt_nxt;
    logic [ADDR_W-1:0] w_mem_waddr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_mem_wen_nxt;

    logic              w_win_vld;
    logic [1:0]        w_win;
    logic [2:0]        w_win_onehot;
    logic              w_own_req;
    logic              w_own_wen;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_data;
    logic              w_cnt_last;

    // Scan starts just after the previous owner; wen plays no part here.
    always_comb begin
        w_win_vld = |req;
        w_win     = 2'd0;
        case (r_last)
            2'd0: begin
                if (req[1])      w_win = 2'd1;
                else if (req[2]) w_win = 2'd2;
                else             w_win = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_win = 2'd2;
                else if (req[0]) w_win = 2'd0;
                else             w_win = 2'd1;
            end
            default: begin
                if (req[0])      w_win = 2'd0;
                else if (req[1]) w_win = 2'd1;
                else             w_win = 2'd2;
            end
        endcase
    end

    assign w_win_onehot = 3'b001 << w_win;

    always_comb begin
        w_own_req  = 1'b0;
        w_own_wen  = 1'b0;
        w_own_addr = waddr[0 +: ADDR_W];
        w_own_data = wdata[0 +: DATA_W];
        case (r_owner)
            2'd0: begin
                w_own_req  = req[0];
                w_own_wen  = wen[0];
                w_own_addr = waddr[0 +: ADDR_W];
                w_own_data = wdata[0 +: DATA_W];
            end
            2'd1: begin
                w_own_req  = req[1];
                w_own_wen  = wen[1];
                w_own_addr = waddr[ADDR_W +: ADDR_W];
                w_own_data = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                w_own_req  = req[2];
                w_own_wen  = wen[2];
                w_own_addr = waddr[2*ADDR_W +: ADDR_W];
                w_own_data = wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                w_own_req = 1'b0;
                w_own_wen = 1'b0;
            end
        endcase
    end

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        w_preempt_nxt   = 1'b0;
        w_mem_waddr_nxt = r_mem_waddr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wen_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_win_onehot;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                // The owner's write on the releasing edge is still forwarded.
                w_mem_waddr_nxt = w_own_addr;
                w_mem_wdata_nxt = w_own_data;
                w_mem_wen_nxt   = w_own_wen;
                w_cnt_nxt       = r_cnt + c_CNT_ONE;
                if (!w_own_req || w_cnt_last) begin
                    w_state_nxt   = S_GAP;
                    w_grant_nxt   = 3'b000;
                    w_owner_nxt   = c_NO_OWNER;
                    w_last_nxt    = r_owner;
                    w_cnt_nxt     = '0;
                    w_preempt_nxt = w_own_req & w_cnt_last;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 3'b000;
                w_owner_nxt = c_NO_OWNER;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'b000;
            r_owner     <= c_NO_OWNER;
            r_last      <= c_LAST_RST;
            r_cnt       <= '0;
            r_preempt   <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_wen   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_preempt   <= w_preempt_nxt;
            r_mem_waddr <= w_mem_waddr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wen   <= w_mem_wen_nxt;
        end
    end

    assign grant       = r_grant;
    assign owner       = r_owner;
    assign preempt     = r_preempt;
    assign mem_waddr   = r_mem_waddr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wenable = r_mem_wen;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_write_arbiter
//  Purpose  : Directed self-checking bench; expected writes go through a
//             scoreboard queue and are popped whenever mem_wenable is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

    localparam int AW = 19;
    localparam int DW = 3;
    localparam int MB = 72;

    logic              clock  = 1'b0;
    logic              resetn = 1'b0;
    logic [2:0]        req    = 3'b000;
    logic [3*AW-1:0]   waddr  = '0;
    logic [3*DW-1:0]   wdata  = '0;
    logic [2:0]        wen    = 3'b000;
    logic [2:0]        grant;
    logic [1:0]        owner;
    logic              preempt;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wenable;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t q[$];
    int  tests = 0;
    int  fails = 0;

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .waddr       (waddr),
        .wdata       (wdata),
        .wen         (wen),
        .grant       (grant),
        .owner       (owner),
        .preempt     (preempt),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wenable (mem_wenable)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [2:0] g, input logic [1:0] o);
        chk({tag, "_grant"}, {29'd0, grant}, {29'd0, g});
        chk({tag, "_owner"}, {30'd0, owner}, {30'd0, o});
    endtask

    task automatic drive_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    // Scoreboard: every forwarded write must match the oldest expected one.
    always @(posedge clock) begin
        wr_t e;
        #1;
        if (mem_wenable === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("mem_waddr", {13'd0, mem_waddr}, {13'd0, e.a});
                chk("mem_wdata", {29'd0, mem_wdata}, {29'd0, e.d});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with stray strobes and addresses present.
        resetn = 1'b0;
        wen    = 3'b111;
        waddr  = {3{19'h55555}};
        wdata  = {3{3'd7}};
        tick();
        tick();
        chk_gnt("rst", 3'b000, 2'd3);
        chk("rst_preempt", {31'd0, preempt}, 32'd0);
        chk("rst_waddr", {13'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", {29'd0, mem_wdata}, 32'd0);
        chk("rst_wen", {31'd0, mem_wenable}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_gnt("idle", 3'b000, 2'd3);
            chk("idle_waddr_hold", {13'd0, mem_waddr}, 32'd0);
        end
        wen = 3'b000;

        // Single 64-write burst from requester 0.
        req = 3'b001;
        tick();
        chk_gnt("sb_start", 3'b001, 2'd0);
        for (int i = 0; i < 64; i++) begin
            wen[0] = 1'b1;
            drive_wr(0, AW'(1000 + i), DW'(i));
            push_wr(AW'(1000 + i), DW'(i));
            if (i == 63) req[0] = 1'b0;
            tick();
            if (i < 63) chk_gnt("sb_hold", 3'b001, 2'd0);
        end
        chk_gnt("sb_gap", 3'b000, 2'd3);
        chk("sb_gap_preempt", {31'd0, preempt}, 32'd0);
        wen = 3'b000;
        tick();
        chk_gnt("sb_idle", 3'b000, 2'd3);
        tick();
        chk("sb_drained", q.size(), 32'd0);

        // Write isolation: non-owners strobe colour 2 without requesting.
        drive_wr(1, 19'd5000, 3'd2);
        drive_wr(2, 19'd6000, 3'd2);
        wen = 3'b110;
        req = 3'b001;
        tick();
        chk_gnt("iso_start", 3'b001, 2'd0);
        for (int i = 0; i < 8; i++) begin
            wen[0] = 1'b1;
            drive_wr(0, AW'(2000 + i), 3'd5);
            push_wr(AW'(2000 + i), 3'd5);
            if (i == 7) req[0] = 1'b0;
            tick();
        end
        chk_gnt("iso_gap", 3'b000, 2'd3);
        wen = 3'b000;
        tick();
        tick();
        chk("iso_drained", q.size(), 32'd0);

        // Forced release after MB cycles, requester 2 joins at cycle 5.
        req = 3'b010;
        tick();
        chk_gnt("pre_start", 3'b010, 2'd1);
        for (int c = 1; c < MB; c++) begin
            if (c == 5) req[2] = 1'b1;
            tick();
            chk_gnt("pre_hold", 3'b010, 2'd1);
            chk("pre_hold_preempt", {31'd0, preempt}, 32'd0);
        end
        tick();
        chk_gnt("pre_gap", 3'b000, 2'd3);
        chk("pre_pulse", {31'd0, preempt}, 32'd1);
        tick();
        chk_gnt("pre_idle", 3'b000, 2'd3);
        chk("pre_pulse_end", {31'd0, preempt}, 32'd0);
        tick();
        chk_gnt("pre_next", 3'b100, 2'd2);
        repeat (3) tick();
        req[2] = 1'b0;
        tick();
        chk_gnt("pre_rel2", 3'b000, 2'd3);
        chk("pre_rel2_preempt", {31'd0, preempt}, 32'd0);
        tick();
        tick();
        chk_gnt("pre_return", 3'b010, 2'd1);
        req[1] = 1'b0;
        tick();
        tick();

        // Reset in grant cycle 10 of requester 2 drops that cycle's write.
        req = 3'b100;
        tick();
        chk_gnt("mr_start", 3'b100, 2'd2);
        for (int i = 1; i < 10; i++) begin
            wen[2] = 1'b1;
            drive_wr(2, AW'(3000 + i), 3'd6);
            push_wr(AW'(3000 + i), 3'd6);
            tick();
            chk_gnt("mr_hold", 3'b100, 2'd2);
        end
        drive_wr(2, 19'd3010, 3'd1);
        resetn = 1'b0;
        tick();
        chk_gnt("mr_rst", 3'b000, 2'd3);
        chk("mr_rst_wen", {31'd0, mem_wenable}, 32'd0);
        wen = 3'b000;
        req = 3'b111;
        tick();
        resetn = 1'b1;
        tick();
        chk_gnt("mr_first", 3'b001, 2'd0);
        chk("mr_drained", q.size(), 32'd0);

        // Round robin with all requesting; each owner releases after 8 cycles.
        for (int k = 0; k < 6; k++) begin
            logic [1:0] e;
            logic [2:0] oh;
            e  = 2'(k % 3);
            oh = 3'b001 << e;
            chk_gnt("rr_start", oh, e);
            for (int j = 2; j <= 8; j++) begin
                tick();
                chk_gnt("rr_hold", oh, e);
            end
            req[e] = 1'b0;
            tick();
            chk_gnt("rr_gap", 3'b000, 2'd3);
            req[e] = 1'b1;
            tick();
            chk_gnt("rr_idle", 3'b000, 2'd3);
            if (k == 5) req = 3'b000;
            tick();
        end
        chk_gnt("rr_end", 3'b000, 2'd3);
        chk("final_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
